imem_loadable: RTL and testbench

Parametrised instruction memory for the single-cycle/multi-cycle core. It holds IW-bit instructions at DEPTH word addresses and serves the fetch stage through a registered, handshaked read port. It adds a synchronous program-load port, so test programs are written word by word instead of being hard-initialised. A sequential clear sweep zeroes every word after reset.

---
 rtl/imem_loadable.sv | 106 ++++++++++
 tb/tb_imem_loadable.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loadable.sv
// Loadable instruction memory: registered fetch port, word-wise program-load
// port, and a post-reset sweep that zeroes every word before use.
module imem_loadable #(
  parameter int unsigned IW    = 19,
  parameter int unsigned AW    = 12,
  parameter int unsigned DEPTH = 4096
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fetch_req,
  input  logic [AW-1:0] address,
  output logic [IW-1:0] instruction,
  output logic          instr_valid,
  output logic          addr_err,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [AW-1:0] load_addr,
  input  logic [IW-1:0] load_data,
  output logic          busy
);

  localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t        r_state;
  logic [AW-1:0] r_clr_ptr;
  logic [IW-1:0] r_instruction;
  logic          r_instr_valid;
  logic          r_addr_err;
  logic          r_load_ready;
  logic          r_busy;
  logic [IW-1:0] r_mem [DEPTH];

  logic w_fetch_in_range;
  logic w_load_in_range;
  logic w_clr_we;
  logic w_load_we;

  assign w_fetch_in_range = ({1'b0, address} < DEPTH_W);
  assign w_load_in_range  = ({1'b0, load_addr} < DEPTH_W);
  assign w_clr_we         = !rst && (r_state == ST_CLEAR);
  // Out-of-range loads are still accepted by the handshake, just never written.
  assign w_load_we        = !rst && (r_state == ST_RUN) && load_valid &&
                            r_load_ready && w_load_in_range;

  // Single write port with no reset so the array stays RAM-inferable.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[r_clr_ptr] <= '0;
    end else if (w_load_we) begin
      r_mem[load_addr] <= load_data;
    end
  end

  // Control FSM and registered fetch response; reads see the pre-write word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_CLEAR;
      r_clr_ptr     <= '0;
      r_busy        <= 1'b1;
      r_load_ready  <= 1'b0;
      r_instruction <= '0;
      r_instr_valid <= 1'b0;
      r_addr_err    <= 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_instr_valid <= 1'b0;
          if (r_clr_ptr == LAST_PTR) begin
            r_state      <= ST_RUN;
            r_busy       <= 1'b0;
            r_load_ready <= 1'b1;
          end else begin
            r_clr_ptr <= r_clr_ptr + AW'(1);
          end
        end
        ST_RUN: begin
          r_busy        <= 1'b0;
          r_load_ready  <= 1'b1;
          r_instr_valid <= fetch_req;
          if (fetch_req) begin
            if (w_fetch_in_range) begin
              r_instruction <= r_mem[address];
              r_addr_err    <= 1'b0;
            end else begin
              r_instruction <= '0;
              r_addr_err    <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_CLEAR;
        end
      endcase
    end
  end

  assign instruction = r_instruction;
  assign instr_valid = r_instr_valid;
  assign addr_err    = r_addr_err;
  assign load_ready  = r_load_ready;
  assign busy        = r_busy;

endmodule

// File: tb/tb_imem_loadable.sv
// Bench for imem_loadable: a power-of-two instance (16 words) and a partial
// instance (12 words) share stimulus and are checked against a reference model.
module tb_imem_loadable;

  localparam int unsigned IW      = 19;
  localparam int unsigned AW      = 4;
  localparam int unsigned DEPTH_A = 16;
  localparam int unsigned DEPTH_B = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          fetch_req;
  logic [AW-1:0] address;
  logic          load_valid;
  logic [AW-1:0] load_addr;
  logic [IW-1:0] load_data;

  logic [IW-1:0] ins_a, ins_b;
  logic          iv_a, iv_b, ae_a, ae_b, lr_a, lr_b, busy_a, busy_b;

  always #5 clk = ~clk;

  imem_loadable #(.IW(IW), .AW(AW), .DEPTH(DEPTH_A)) u_dut_a (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .address(address),
    .instruction(ins_a), .instr_valid(iv_a), .addr_err(ae_a),
    .load_valid(load_valid), .load_ready(lr_a), .load_addr(load_addr),
    .load_data(load_data), .busy(busy_a)
  );

  imem_loadable #(.IW(IW), .AW(AW), .DEPTH(DEPTH_B)) u_dut_b (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .address(address),
    .instruction(ins_b), .instr_valid(iv_b), .addr_err(ae_b),
    .load_valid(load_valid), .load_ready(lr_b), .load_addr(load_addr),
    .load_data(load_data), .busy(busy_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: index 0 is the 16-word instance, 1 the 12-word one.
  logic [IW-1:0] m_mem [2][16];
  int            m_clr [2];
  logic [IW-1:0] e_ins [2];
  logic          e_iv [2], e_ae [2], e_busy [2], e_lr [2];

  typedef struct {
    logic          fe;
    logic [AW-1:0] fa;
    logic          lv;
    logic [AW-1:0] la;
    logic [IW-1:0] ld;
    logic [IW-1:0] x_ins;
    logic          x_iv;
    logic          x_ae;
  } vec_t;

  vec_t vt [15];

  function automatic int unsigned depth_of(input int d);
    return (d == 0) ? DEPTH_A : DEPTH_B;
  endfunction

  function automatic vec_t mk(input logic fe, input int fa, input logic lv,
                              input int la, input int ld, input int x_ins,
                              input logic x_iv, input logic x_ae);
    vec_t v;
    v.fe = fe; v.fa = AW'(fa); v.lv = lv; v.la = AW'(la); v.ld = IW'(ld);
    v.x_ins = IW'(x_ins); v.x_iv = x_iv; v.x_ae = x_ae;
    return v;
  endfunction

  task automatic check(input string name, input int d, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d got=%h exp=%h t=%0t", name, d, got, exp, $time);
    end
  endtask

  // Expected post-edge outputs from the current inputs and model state.
  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      int unsigned dep;
      dep = depth_of(d);
      if (rst) begin
        for (int i = 0; i < 16; i++) m_mem[d][i] = '0;
        m_clr[d] = int'(dep);
        e_busy[d] = 1'b1; e_lr[d] = 1'b0;
        e_ins[d] = '0; e_iv[d] = 1'b0; e_ae[d] = 1'b0;
      end else if (m_clr[d] > 0) begin
        m_clr[d]--;
        e_iv[d]   = 1'b0;
        e_busy[d] = (m_clr[d] > 0);
        e_lr[d]   = !e_busy[d];
      end else begin
        e_busy[d] = 1'b0;
        e_lr[d]   = 1'b1;
        e_iv[d]   = fetch_req;
        if (fetch_req) begin
          if (int'(address) < int'(dep)) begin
            e_ins[d] = m_mem[d][address];
            e_ae[d]  = 1'b0;
          end else begin
            e_ins[d] = '0;
            e_ae[d]  = 1'b1;
          end
        end
        if (load_valid && (int'(load_addr) < int'(dep)))
          m_mem[d][load_addr] = load_data;
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("busy",        0, 32'(busy_a), 32'(e_busy[0]));
    check("load_ready",  0, 32'(lr_a),   32'(e_lr[0]));
    check("instr_valid", 0, 32'(iv_a),   32'(e_iv[0]));
    check("instruction", 0, 32'(ins_a),  32'(e_ins[0]));
    check("addr_err",    0, 32'(ae_a),   32'(e_ae[0]));
    check("busy",        1, 32'(busy_b), 32'(e_busy[1]));
    check("load_ready",  1, 32'(lr_b),   32'(e_lr[1]));
    check("instr_valid", 1, 32'(iv_b),   32'(e_iv[1]));
    check("instruction", 1, 32'(ins_b),  32'(e_ins[1]));
    check("addr_err",    1, 32'(ae_b),   32'(e_ae[1]));
  endtask

  task automatic idle();
    rst = 1'b0; fetch_req = 1'b0; load_valid = 1'b0;
  endtask

  // Runs after rst drops; checks how many edges each instance stays busy.
  task automatic count_sweep(input string name);
    int first_a, first_b;
    first_a = 0; first_b = 0;
    idle();
    for (int k = 1; k <= 24; k++) begin
      step();
      if (first_a == 0 && !busy_a) first_a = k;
      if (first_b == 0 && !busy_b) first_b = k;
    end
    check({name, "_busy_edges"}, 0, 32'(first_a), 32'(DEPTH_A));
    check({name, "_busy_edges"}, 1, 32'(first_b), 32'(DEPTH_B));
    check({name, "_ready"}, 0, 32'(lr_a), 32'd1);
    check({name, "_ready"}, 1, 32'(lr_b), 32'd1);
  endtask

  initial begin
    rst = 1'b1; fetch_req = 1'b0; address = '0;
    load_valid = 1'b0; load_addr = '0; load_data = '0;

    vt[0]  = mk(0, 0,  1, 7,  'h01946, 'h00000, 0, 0);
    vt[1]  = mk(0, 0,  1, 8,  'h0580F, 'h00000, 0, 0);
    vt[2]  = mk(1, 7,  0, 0,  0,       'h01946, 1, 0);
    vt[3]  = mk(1, 8,  0, 0,  0,       'h0580F, 1, 0);
    vt[4]  = mk(0, 0,  1, 9,  'h0720B, 'h0580F, 0, 0);
    vt[5]  = mk(1, 9,  1, 9,  'h7FFFF, 'h0720B, 1, 0);
    vt[6]  = mk(1, 9,  0, 0,  0,       'h7FFFF, 1, 0);
    vt[7]  = mk(1, 13, 0, 0,  0,       'h00000, 1, 0);
    vt[8]  = mk(0, 0,  1, 14, 'h12345, 'h00000, 0, 0);
    vt[9]  = mk(1, 14, 0, 0,  0,       'h12345, 1, 0);
    vt[10] = mk(1, 7,  0, 0,  0,       'h01946, 1, 0);
    for (int i = 11; i < 15; i++) vt[i] = mk(0, 0, 0, 0, 0, 'h01946, 0, 0);

    // Reset for three cycles, then the sweep.
    for (int i = 0; i < 3; i++) step();
    check("reset_busy",  0, 32'(busy_a), 32'd1);
    check("reset_ready", 1, 32'(lr_b),   32'd0);
    count_sweep("sweep");

    // Every word reads back zero one cycle after its request.
    for (int a = 0; a < 16; a++) begin
      fetch_req = 1'b1; address = AW'(a);
      step();
      check("swept_word",  0, 32'(ins_a), 32'd0);
      check("swept_valid", 0, 32'(iv_a),  32'd1);
    end
    check("oob_after_sweep", 1, 32'(ae_b), 32'd1);

    // Directed table on the 16-word instance; both instances follow the model.
    for (int i = 0; i < 15; i++) begin
      rst = 1'b0;
      fetch_req = vt[i].fe; address = vt[i].fa;
      load_valid = vt[i].lv; load_addr = vt[i].la; load_data = vt[i].ld;
      step();
      check($sformatf("vec%0d_ins", i), 0, 32'(ins_a), 32'(vt[i].x_ins));
      check($sformatf("vec%0d_iv",  i), 0, 32'(iv_a),  32'(vt[i].x_iv));
      check($sformatf("vec%0d_ae",  i), 0, 32'(ae_a),  32'(vt[i].x_ae));
    end

    // Out-of-range fetch and discarded load on the 12-word instance.
    idle(); fetch_req = 1'b1; address = AW'(13);
    step();
    check("oob_fetch_ins", 1, 32'(ins_b), 32'd0);
    check("oob_fetch_err", 1, 32'(ae_b),  32'd1);
    idle(); load_valid = 1'b1; load_addr = AW'(14); load_data = IW'('h12345);
    step();
    check("oob_load_ready", 1, 32'(lr_b), 32'd1);
    idle();
    for (int a = 0; a < 12; a++) begin
      fetch_req = 1'b1; address = AW'(a);
      step();
    end

    // Reset during a fetch, then again mid-sweep at clr_ptr=5.
    idle(); load_valid = 1'b1; load_addr = AW'(3); load_data = IW'('h01946);
    step();
    idle(); rst = 1'b1; fetch_req = 1'b1; address = AW'(3);
    step();
    check("rst_edge_valid", 0, 32'(iv_a), 32'd0);
    check("rst_edge_ins",   0, 32'(ins_a), 32'd0);
    idle();
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    step();
    count_sweep("resweep");
    idle(); fetch_req = 1'b1; address = AW'(3);
    step();
    check("post_reset_word",  0, 32'(ins_a), 32'd0);
    check("post_reset_valid", 0, 32'(iv_a),  32'd1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      rst        = ($urandom_range(0, 99) == 0);
      fetch_req  = 1'($urandom_range(0, 1));
      address    = AW'($urandom_range(0, 15));
      load_valid = 1'($urandom_range(0, 1));
      load_addr  = AW'($urandom_range(0, 15));
      load_data  = IW'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
